// File: rtl/seq_div_16_bit_pkg.sv
// Shared arithmetic package: divider state encoding and default operand width.
package seq_div_16_bit_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_16_bit_sub.sv
// Trial subtractor x - y: generate/propagate carry adder on ~y with carry-in 1.
module sub_16_bit #(
  parameter int W = 17
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;

  assign gen  = x & ~y;
  assign prop = x ^ ~y;

  always_comb begin
    carry[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  // A carry out of the top bit means x >= y, i.e. no borrow.
  assign diff   = prop ^ carry[W-1:0];
  assign borrow = ~carry[W];

endmodule

// File: rtl/seq_div_16_bit.sv
// Unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro SEQ_DIV_DBZ_EN: short-circuit divide-by-zero straight to DONE with dbz=1.
module seq_div_16_bit
  import seq_div_16_bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             unused_diff_msb;

  // The dividend register shifts out its MSB into the remainder and fills with quotient bits.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  sub_16_bit #(
    .W (WIDTH + 1)
  ) u_sub (
    .x      (shifted),
    .y      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // A committed difference is always below the divisor, so its MSB is never needed.
  assign unused_diff_msb = diff[WIDTH];

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d      = a;
          dvs_d      = b;
          rem_d      = '0;
          cnt_d      = '0;
          dbz_d      = 1'b0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
`ifdef SEQ_DIV_DBZ_EN
          if (b == '0) begin
            dvd_d       = '1;
            rem_d       = a;
            dbz_d       = 1'b1;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = dvd_q;
  assign rem       = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div_16_bit.sv
// Self-checking bench for seq_div_16_bit: arithmetic reference model plus directed and random operands.
module tb_seq_div_16_bit;

`ifdef SEQ_DIV_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        dbz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        exp_vld = 1'b0;
  logic [15:0] exp_q;
  logic [15:0] exp_r;
  logic        exp_dbz;

  seq_div_16_bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Whenever a result is presented it must match the arithmetic model of the accepted pair.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_vld) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("mon_quot", {16'd0, quot}, {16'd0, exp_q});
        chk("mon_rem", {16'd0, rem}, {16'd0, exp_r});
        chk("mon_dbz", {31'd0, dbz}, {31'd0, exp_dbz});
        chk("mon_in_ready_in_done", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input int hold,
                       input bit lit, input logic [15:0] lq, input logic [15:0] lr);
    int n;
    int t;
    int exp_lat;
    logic [15:0] hq;
    logic [15:0] hr;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    if (bv == 16'd0) begin
      exp_q   = 16'hFFFF;
      exp_r   = av;
      exp_dbz = DBZ_EN;
    end else begin
      exp_q   = av / bv;
      exp_r   = av % bv;
      exp_dbz = 1'b0;
    end
    exp_vld   = 1'b1;
    exp_lat   = (bv == 16'd0 && DBZ_EN) ? 0 : 16;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    t = cyc;
    in_valid = 1'b0;
    n = 0;
    // Operand lines and in_valid are scrambled while the division runs.
    while (!out_valid && n < 40) begin
      a        = 16'($urandom);
      b        = 16'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - t, exp_lat);
    if (lit) begin
      chk("lit_quot", {16'd0, quot}, {16'd0, lq});
      chk("lit_rem", {16'd0, rem}, {16'd0, lr});
      chk("lit_dbz", {31'd0, dbz}, {31'd0, (bv == 16'd0) && DBZ_EN});
    end
    for (int i = 0; i < hold; i++) begin
      hq       = quot;
      hr       = rem;
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_quot", {16'd0, quot}, {16'd0, hq});
      chk("hold_rem", {16'd0, rem}, {16'd0, hr});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_vld   = 1'b0;
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quot", {16'd0, quot}, 32'd0);
    chk("rst_rem", {16'd0, rem}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'd9404, 16'd217, 0, 1'b1, 16'd43, 16'd73);
    do_op(16'd65535, 16'd346, 1, 1'b1, 16'd189, 16'd141);
    do_op(16'd4582, 16'd3, 0, 1'b1, 16'd1527, 16'd1);
    do_op(16'd27, 16'd8693, 5, 1'b1, 16'd0, 16'd27);
    do_op(16'd4582, 16'd0, 2, 1'b1, 16'd65535, 16'd4582);

    // Reset in the middle of a division discards it.
    a        = 16'd9404;
    b        = 16'd217;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_quot", {16'd0, quot}, 32'd0);
    chk("abort_rem", {16'd0, rem}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    do_op(16'd27, 16'd8693, 0, 1'b1, 16'd0, 16'd27);

    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      do_op(ra, rb, int'($urandom_range(0, 2)), 1'b0, 16'd0, 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div_16_bit.md
SEQ_DIV_16_BIT -- requirements
Module: seq_div_16_bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, dividend/divisor presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, WIDTH, unsigned dividend.
REQ-007 SHALL have port b, input, WIDTH, unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1, quotient/remainder valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port quot, output, WIDTH, quotient.
REQ-011 SHALL have port rem, output, WIDTH, remainder.
REQ-012 SHALL have port dbz, output, 1, divide-by-zero flag, qualified by out_valid.

Function
REQ-013 SHALL implement an unsigned restoring divider, one quotient bit per BUSY cycle, MSB first.
REQ-014 SHALL use the states IDLE, BUSY and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE on in_valid=1, capture a and b, clear the partial remainder and iteration counter, and go to BUSY.
REQ-017 SHALL, in each BUSY step, shift {partial remainder, dividend} left by 1 and compute a WIDTH+1-bit trial difference remainder-minus-divisor; borrow=0 commits the difference and sets the quotient bit to 1, borrow=1 restores and sets it to 0.
REQ-018 SHALL leave BUSY after exactly WIDTH steps; with the operand pair accepted at edge t, out_valid rises after edge t+WIDTH.
REQ-019 SHALL hold quot, rem and dbz stable in DONE until out_valid and out_ready are both 1, then return to IDLE on that edge.
REQ-020 SHALL accept the next operand pair no earlier than the cycle after the result handshake; in_valid in DONE is ignored.
REQ-021 SHALL ignore in_valid and hold the captured operands while BUSY; input changes do not affect the result in progress.
REQ-022 SHALL satisfy quot*b+rem == a and rem < b for every b != 0.

Reset
REQ-023 SHALL, while rst=1, force the state to IDLE, in_ready=1, out_valid=0, and quot, rem and dbz to 0, regardless of clk.
REQ-024 SHALL abort any division in progress when rst is asserted and produce no result for it.

Configuration
REQ-025 SHALL implement the feature gated by macro SEQ_DIV_DBZ_EN.
REQ-026 SHALL, with SEQ_DIV_DBZ_EN defined, go from IDLE straight to DONE when b=0 is accepted, with dbz=1, quot=all ones and rem=a, and out_valid one cycle after acceptance.
REQ-027 SHALL, without SEQ_DIV_DBZ_EN, hold dbz at 0 and run the normal WIDTH-step sequence for b=0, giving quot=all ones and rem=a at normal latency.

Structure
REQ-028 SHALL take the state-encoding typedef (IDLE/BUSY/DONE) and the WIDTH default constant from the shared arithmetic package.
REQ-029 SHALL put the WIDTH+1-bit trial subtraction (difference and borrow-out) in the single sub-module sub_16_bit, built from the team's existing carry-lookahead adder cells with an inverted subtrahend and carry-in of 1.

Verification
REQ-030 SHALL check: a=9404, b=217 -> after 16 BUSY cycles, quot=43, rem=73, dbz=0.
REQ-031 SHALL check: a=65535, b=346 -> quot=189, rem=141. Also check a=4582, b=3 -> quot=1527, rem=1.
REQ-032 SHALL check: a=27, b=8693 -> quot=0, rem=27. Also hold out_ready=0 for 5 cycles -> out_valid, quot and rem stay stable and in_ready=0 throughout.
REQ-033 SHALL check: a=4582, b=0 -> with the macro, dbz=1, quot=65535, rem=4582 one cycle after acceptance; without it, dbz=0 with the same values after 16 steps.
REQ-034 SHALL check: rst asserted at BUSY step 7 of 9404/217 -> out_valid=0 and in_ready=1 immediately; a following 27/8693 request completes correctly.
